key_matrix_scanner: RTL and testbench
=====================================

Name: key_matrix_scanner

Overview:
- Reads a 6x6 passive button matrix: drives rows one at a time, samples column sense lines, debounces each key, and exposes a 36-bit debounced key image.
- Bit mapping matches the LED matrix image: index = row*6 + col, so a key image maps directly onto a display image.
- Emits press/release events over a valid/ready handshake for the application logic.

Parameters:
- CLK_FREQ, 12000000, clk frequency in Hz.
- SCAN_RATE_HZ, 3600, row-step rate; one row is driven per tick, so a full frame takes 6 ticks.
- DEBOUNCE_SCANS, 4, number of consecutive identical frame samples (1..7) needed to change a key's debounced state.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- row_drive  output  6  active-low one-hot row strobe; bit r low means row r is driven.
- col_sense  input  6  active-low column sense (pulled up externally); bit c low means the key at (active row, c) is closed.
- key_state  output  36  debounced image; 1 = pressed; bit = row*6+col.
- event_valid  output  1  an event is presented.
- event_ready  input  1  consumer accepts the event when event_valid and event_ready are both 1 on a posedge.
- event_key  output  6  key index 0..35 of the event.
- event_pressed  output  1  1 = press, 0 = release.

Behaviour:
- Reset (rst=0):
  - row_drive=6'b111110 (row 0).
  - key_state=0, event_valid=0, event_key=0, event_pressed=0.
  - Prescaler, row counter, all debounce counters and the internal reported image are cleared to 0.
  - Reset mid-scan or mid-handshake abandons everything; a pending event is dropped.
- Prescaler:
  - Counts 0..TICK-1, where TICK = CLK_FREQ/SCAN_RATE_HZ (integer division, minimum 1).
  - A one-cycle tick fires when the count equals TICK-1, then the count wraps to 0.
- Row scan:
  - On a tick, sample ~col_sense into raw bits [row*6+5 : row*6] of the current row. The row has therefore been driven for a full tick period before it is sampled.
  - In the same cycle, advance the row 0,1,2,3,4,5,0,… and update row_drive registered, so exactly one bit is low at all times.
  - Row values above 5 cannot occur.
- Debounce (evaluated per key when its row is sampled):
  - If the sampled bit equals key_state[k], clear cnt[k].
  - Otherwise increment cnt[k]. When cnt[k] reaches DEBOUNCE_SCANS-1 and the bit still differs, toggle key_state[k] and clear cnt[k].
  - A change therefore needs DEBOUNCE_SCANS consecutive disagreeing samples, i.e. DEBOUNCE_SCANS frames.
  - cnt is 3 bits wide and never wraps.
- Event generation (reported image R, 36 bits):
  - pending = key_state XOR R.
  - When event_valid=0 and pending is non-zero, on the next posedge:
    - Load event_key with the lowest set index of pending.
    - Load event_pressed with key_state at that index.
    - Set event_valid=1.
  - While event_valid=1, event_key and event_pressed are held stable until accepted. This holds even if the key changes state meanwhile.
  - On acceptance: R[event_key] <= event_pressed and event_valid <= 0. The next event may be presented no earlier than the following cycle, so back-to-back events are spaced at least 2 cycles apart.
  - Coalescing: if a key flips and flips back before it is reported, pending clears and no event is emitted. If it flips back after being loaded, the loaded event is still delivered, followed by the opposite event.
  - Scanning and debouncing never stall regardless of event_ready.
  - Simultaneous changes on several keys are reported in ascending index order, one per handshake.
- Outputs are registered; no combinational path exists from col_sense or event_ready to any output.

Test Plan:
- Reset/idle (CLK_FREQ=1200, SCAN_RATE_HZ=100 → TICK=12; DEBOUNCE_SCANS=3; col_sense=6'h3F) -> row_drive walks 3E,3D,3B,37,2F,1F,3E stepping every 12 cycles; key_state=0; event_valid never asserts.
- Single press: hold key 14 (row 2, col 2 low while row 2 is driven) -> key_state[14]=1 on the 3rd row-2 sample; event_valid=1 with event_key=14 and event_pressed=1; with event_ready=1, acceptance takes 1 cycle. Release -> event_key=14, event_pressed=0 after 3 frames.
- Bounce: key 0 toggles every frame for 10 frames -> key_state[0] stays 0 and no event is emitted. A glitch lasting 2 frames is also rejected.
- Multi-key with backpressure: press 35, 7 and 20 in the same frame with event_ready=0 -> event_key=7 is held stable. Then raise event_ready=1 -> events arrive in order 7, 20, 35, spaced 2 cycles apart.
- Coalesce: with event_ready=0, press key 5 and release it before it is reported -> key 5 is loaded, so press(5) is held and then delivered, followed by release(5). A separate case, where key 9 changes and reverts while the slot is occupied by another key, produces no key 9 event.
- Reset mid-handshake: event_valid=1, drive rst=0 for 1 cycle -> event_valid=0, key_state=0, row_drive=3E on the next cycle. Keys still held re-report after DEBOUNCE_SCANS frames.

Source files
------------

// File: rtl/key_matrix_scanner_if.sv
// Key event handshake bundle between the matrix scanner and its consumer.
//   event_valid   : an event is presented (producer -> consumer)
//   event_ready   : consumer accepts when valid & ready on posedge
//   event_key     : key index 0..35 (row*6 + col)
//   event_pressed : 1 = press, 0 = release
interface key_matrix_scanner_if;
   logic       event_valid;
   logic       event_ready;
   logic [5:0] event_key;
   logic       event_pressed;

   modport master (
      output event_valid,
      output event_key,
      output event_pressed,
      input  event_ready
   );

   modport slave (
      input  event_valid,
      input  event_key,
      input  event_pressed,
      output event_ready
   );
endinterface

// File: rtl/key_matrix_scanner.sv
// 6x6 passive key matrix scanner with per-key debounce and press/release events.
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   row_drive  : active-low one-hot row strobe (bit r low = row r driven)
//   col_sense  : active-low column sense lines for the driven row
//   key_state  : debounced key image, 1 = pressed, bit = row*6 + col
//   evt        : event handshake (valid/ready, key index, press/release)
module key_matrix_scanner #(
   parameter int unsigned CLK_FREQ       = 12000000,
   parameter int unsigned SCAN_RATE_HZ   = 3600,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [5:0]           row_drive,
   input  logic [5:0]           col_sense,
   output logic [35:0]          key_state,
   key_matrix_scanner_if.master evt
);

   localparam int unsigned NROW     = 6;
   localparam int unsigned NCOL     = 6;
   localparam int unsigned NKEY     = NROW * NCOL;
   localparam int unsigned TICK_DIV = CLK_FREQ / SCAN_RATE_HZ;
   localparam int unsigned TICK     = (TICK_DIV < 1) ? 1 : TICK_DIV;
   localparam int unsigned PW       = (TICK > 1) ? $clog2(TICK) : 1;
   localparam int unsigned CW       = 3;
   localparam int unsigned RW       = 3;
   localparam int unsigned KW       = 6;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS - 1);

   typedef enum logic {
      EV_IDLE,
      EV_PRESENT
   } ev_state_t;

   logic [PW-1:0]   presc;
   logic            tick_c;
   logic [RW-1:0]   row;
   logic [RW-1:0]   row_next_c;
   logic [5:0]      sample_c;
   logic [CW-1:0]   cnt [NKEY];
   logic [NKEY-1:0] reported;
   logic [NKEY-1:0] pend_c;
   logic            pend_any_c;
   logic [KW-1:0]   pend_idx_c;
   ev_state_t       ev_state;

   // Row-step prescaler: one-cycle tick every TICK clocks.
   assign tick_c = (presc == PW'(TICK - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc <= '0;
      end else if (tick_c) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Row sequencer 0..5; row_drive is registered alongside the counter.
   assign row_next_c = (row == RW'(NROW - 1)) ? '0 : row + RW'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         row       <= '0;
         row_drive <= 6'b111110;
      end else if (tick_c) begin
         row       <= row_next_c;
         row_drive <= ~(6'b000001 << row_next_c);
      end
   end

   // Closed key pulls its column low, so invert to get 1 = pressed.
   assign sample_c = ~col_sense;

   // Per-key debounce, evaluated only for keys of the row being sampled.
   // The row has been driven for a full tick period when its tick arrives.
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_state <= '0;
         for (int k = 0; k < NKEY; k++) begin
            cnt[k] <= '0;
         end
      end else if (tick_c) begin
         for (int r = 0; r < NROW; r++) begin
            if (row == RW'(r)) begin
               for (int c = 0; c < NCOL; c++) begin
                  if (sample_c[c] == key_state[r*NCOL + c]) begin
                     cnt[r*NCOL + c] <= '0;
                  end else if (cnt[r*NCOL + c] == DEB_LAST) begin
                     key_state[r*NCOL + c] <= ~key_state[r*NCOL + c];
                     cnt[r*NCOL + c]       <= '0;
                  end else begin
                     cnt[r*NCOL + c] <= cnt[r*NCOL + c] + CW'(1);
                  end
               end
            end
         end
      end
   end

   // Keys whose debounced state differs from what the consumer last saw;
   // lowest index wins so simultaneous changes come out in ascending order.
   always_comb begin
      pend_c     = key_state ^ reported;
      pend_any_c = |pend_c;
      pend_idx_c = '0;
      for (int k = NKEY - 1; k >= 0; k--) begin
         if (pend_c[k]) begin
            pend_idx_c = KW'(k);
         end
      end
   end

   // Event slot. A loaded event is frozen until accepted; the reported image
   // only moves on acceptance, so a flip-and-revert that never reaches the
   // slot leaves no trace, while one that was loaded is followed by its undo.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ev_state          <= EV_IDLE;
         evt.event_valid   <= 1'b0;
         evt.event_key     <= '0;
         evt.event_pressed <= 1'b0;
         reported          <= '0;
      end else begin
         case (ev_state)
            EV_IDLE: begin
               if (pend_any_c) begin
                  evt.event_key     <= pend_idx_c;
                  evt.event_pressed <= key_state[pend_idx_c];
                  evt.event_valid   <= 1'b1;
                  ev_state          <= EV_PRESENT;
               end
            end
            EV_PRESENT: begin
               if (evt.event_ready) begin
                  reported[evt.event_key] <= evt.event_pressed;
                  evt.event_valid         <= 1'b0;
                  ev_state                <= EV_IDLE;
               end
            end
            default: begin
               ev_state        <= EV_IDLE;
               evt.event_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench for key_matrix_scanner: directed vector table, corner
// sequences and randomized key activity against a frame-level reference model.
module tb_key_matrix_scanner;

   localparam int unsigned CF    = 1200;
   localparam int unsigned SR    = 100;
   localparam int unsigned DEB   = 3;
   localparam int unsigned TICK  = CF / SR;
   localparam int unsigned FRAME = TICK * 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [35:0] phys;
   logic [5:0]  row_drive;
   logic [5:0]  col_sense;
   logic [35:0] key_state;

   key_matrix_scanner_if evt_if ();
   assign evt_if.event_ready = ready;

   key_matrix_scanner #(
      .CLK_FREQ       (CF),
      .SCAN_RATE_HZ   (SR),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_drive (row_drive),
      .col_sense (col_sense),
      .key_state (key_state),
      .evt       (evt_if)
   );

   always #5 clk = ~clk;

   // Physical matrix: a closed key pulls its column low while its row is driven.
   always_comb begin
      col_sense = 6'h3F;
      for (int r = 0; r < 6; r++) begin
         if (!row_drive[r]) begin
            for (int c = 0; c < 6; c++) begin
               if (phys[r*6 + c]) col_sense[c] = 1'b0;
            end
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   int valid_cycles = 0;
   logic [6:0] log_ev [$];
   int         log_t  [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference model: time counted in clocks since reset, rows sampled in
   // tick order, each key a run-length of disagreeing frame samples.
   int          m_cyc, m_ticks;
   int          m_run [36];
   logic [35:0] m_key, m_rep;
   logic        m_valid, m_epress;
   int          m_ekey;

   task automatic model_step();
      if (!rst) begin
         m_cyc = 0; m_ticks = 0; m_key = '0; m_rep = '0;
         m_valid = 1'b0; m_ekey = 0; m_epress = 1'b0;
         for (int k = 0; k < 36; k++) m_run[k] = 0;
      end else begin
         if (m_valid) begin
            if (ready) begin
               m_rep[m_ekey] = m_epress;
               m_valid = 1'b0;
            end
         end else begin
            for (int k = 0; k < 36; k++) begin
               if (m_key[k] != m_rep[k]) begin
                  m_ekey = k; m_epress = m_key[k]; m_valid = 1'b1;
                  break;
               end
            end
         end
         m_cyc++;
         if (m_cyc % TICK == 0) begin
            for (int c = 0; c < 6; c++) begin
               int k;
               k = (m_ticks % 6) * 6 + c;
               if (phys[k] != m_key[k]) begin
                  m_run[k]++;
                  if (m_run[k] == DEB) begin
                     m_key[k] = ~m_key[k];
                     m_run[k] = 0;
                  end
               end else begin
                  m_run[k] = 0;
               end
            end
            m_ticks++;
         end
      end
   endtask

   // One clock: log accepted events, advance model, compare on the falling edge.
   task automatic cyc();
      logic [5:0] one6;
      logic [5:0] exp_row;
      one6 = 6'd1;
      if (evt_if.event_valid && ready) begin
         log_ev.push_back({evt_if.event_pressed, evt_if.event_key});
         log_t.push_back(cycle);
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      cycle++;
      exp_row = ~(one6 << (m_ticks % 6));
      chk("model row_drive", 64'(row_drive), 64'(exp_row));
      chk("model key_state", 64'(key_state), 64'(m_key));
      chk("model event_valid", 64'(evt_if.event_valid), 64'(m_valid));
      if (m_valid) begin
         chk("model event_key", 64'(evt_if.event_key), 64'(m_ekey));
         chk("model event_pressed", 64'(evt_if.event_pressed), 64'(m_epress));
      end
      if (evt_if.event_valid) valid_cycles++;
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n;
      n = 0;
      while (!evt_if.event_valid && n < budget) begin
         cyc();
         n++;
      end
      chk(name, 64'(evt_if.event_valid), 64'd1);
   endtask

   task automatic frames(input int n);
      repeat (n * FRAME) cyc();
   endtask

   typedef struct {
      int unsigned ncyc;
      logic [35:0] phys;
      logic        ready;
      logic [5:0]  exp_row;
      logic [35:0] exp_state;
      logic        exp_valid;
      logic [5:0]  exp_key;
      logic        exp_pressed;
   } vec_t;

   vec_t vt [16];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [35:0] k14, one36;
      int n;
      k14   = 36'd1 << 14;
      one36 = 36'd1;

      // Row walk at idle, then key 14 press and release with ready high.
      vt[0]  = '{11,  '0,  1'b0, 6'h3E, '0,  1'b0, 6'd0,  1'b0};
      vt[1]  = '{1,   '0,  1'b0, 6'h3D, '0,  1'b0, 6'd0,  1'b0};
      vt[2]  = '{11,  '0,  1'b0, 6'h3D, '0,  1'b0, 6'd0,  1'b0};
      vt[3]  = '{1,   '0,  1'b0, 6'h3B, '0,  1'b0, 6'd0,  1'b0};
      vt[4]  = '{12,  '0,  1'b0, 6'h37, '0,  1'b0, 6'd0,  1'b0};
      vt[5]  = '{12,  '0,  1'b0, 6'h2F, '0,  1'b0, 6'd0,  1'b0};
      vt[6]  = '{12,  '0,  1'b0, 6'h1F, '0,  1'b0, 6'd0,  1'b0};
      vt[7]  = '{12,  '0,  1'b0, 6'h3E, '0,  1'b0, 6'd0,  1'b0};
      vt[8]  = '{179, k14, 1'b1, 6'h3B, '0,  1'b0, 6'd0,  1'b0};
      vt[9]  = '{1,   k14, 1'b1, 6'h37, k14, 1'b0, 6'd0,  1'b0};
      vt[10] = '{1,   k14, 1'b1, 6'h37, k14, 1'b1, 6'd14, 1'b1};
      vt[11] = '{1,   k14, 1'b1, 6'h37, k14, 1'b0, 6'd0,  1'b0};
      vt[12] = '{213, '0,  1'b1, 6'h3B, k14, 1'b0, 6'd0,  1'b0};
      vt[13] = '{1,   '0,  1'b1, 6'h37, '0,  1'b0, 6'd0,  1'b0};
      vt[14] = '{1,   '0,  1'b1, 6'h37, '0,  1'b1, 6'd14, 1'b0};
      vt[15] = '{1,   '0,  1'b1, 6'h37, '0,  1'b0, 6'd0,  1'b0};

      rst = 1'b0; ready = 1'b0; phys = '0;
      repeat (3) cyc();
      chk("reset row_drive", 64'(row_drive), 64'h3E);
      chk("reset key_state", 64'(key_state), 64'd0);
      chk("reset event_valid", 64'(evt_if.event_valid), 64'd0);
      chk("reset event_key", 64'(evt_if.event_key), 64'd0);
      chk("reset event_pressed", 64'(evt_if.event_pressed), 64'd0);
      rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         phys  = vt[i].phys;
         ready = vt[i].ready;
         repeat (vt[i].ncyc) cyc();
         chk($sformatf("vec%0d row_drive", i), 64'(row_drive), 64'(vt[i].exp_row));
         chk($sformatf("vec%0d key_state", i), 64'(key_state), 64'(vt[i].exp_state));
         chk($sformatf("vec%0d event_valid", i), 64'(evt_if.event_valid), 64'(vt[i].exp_valid));
         if (vt[i].exp_valid) begin
            chk($sformatf("vec%0d event_key", i), 64'(evt_if.event_key), 64'(vt[i].exp_key));
            chk($sformatf("vec%0d event_pressed", i), 64'(evt_if.event_pressed), 64'(vt[i].exp_pressed));
         end
      end

      // Bounce: key 0 alternates each frame, then a two-frame glitch.
      ready = 1'b1; valid_cycles = 0;
      for (int f = 0; f < 10; f++) begin
         phys = (f % 2 == 1) ? one36 : '0;
         frames(1);
      end
      phys = '0;
      frames(1);
      phys = one36;
      frames(2);
      phys = '0;
      frames(3);
      chk("bounce no event", 64'(valid_cycles), 64'd0);
      chk("bounce key0", 64'(key_state[0]), 64'd0);

      // Multi-key with backpressure; align so row 1 is the next row sampled.
      ready = 1'b0;
      n = 0;
      while (row_drive == 6'h3D && n < 200) begin cyc(); n++; end
      while (row_drive != 6'h3D && n < 200) begin cyc(); n++; end
      chk("sync row1", 64'(row_drive), 64'h3D);
      phys = (one36 << 35) | (one36 << 7) | (one36 << 20);
      frames(4);
      for (int i = 0; i < 4; i++) begin
         chk("backpressure key", 64'(evt_if.event_key), 64'd7);
         chk("backpressure valid", 64'(evt_if.event_valid), 64'd1);
         repeat (3) cyc();
      end
      log_ev.delete(); log_t.delete();
      ready = 1'b1;
      repeat (10) cyc();
      chk("multi count", 64'(log_ev.size()), 64'd3);
      if (log_ev.size() >= 3) begin
         chk("multi ev0", 64'(log_ev[0]), 64'({1'b1, 6'd7}));
         chk("multi ev1", 64'(log_ev[1]), 64'({1'b1, 6'd20}));
         chk("multi ev2", 64'(log_ev[2]), 64'({1'b1, 6'd35}));
         chk("multi spacing01", 64'(log_t[1] - log_t[0]), 64'd2);
         chk("multi spacing12", 64'(log_t[2] - log_t[1]), 64'd2);
      end
      phys = '0;
      frames(4);

      // Coalesce after load: press 5, release before acceptance.
      ready = 1'b0; log_ev.delete(); log_t.delete();
      phys = one36 << 5;
      wait_valid(5 * FRAME, "coalesce5 wait");
      chk("coalesce5 key", 64'(evt_if.event_key), 64'd5);
      phys = '0;
      frames(4);
      chk("coalesce5 state", 64'(key_state[5]), 64'd0);
      chk("coalesce5 held key", 64'(evt_if.event_key), 64'd5);
      chk("coalesce5 held pressed", 64'(evt_if.event_pressed), 64'd1);
      ready = 1'b1;
      repeat (6) cyc();
      chk("coalesce5 count", 64'(log_ev.size()), 64'd2);
      if (log_ev.size() >= 2) begin
         chk("coalesce5 ev0", 64'(log_ev[0]), 64'({1'b1, 6'd5}));
         chk("coalesce5 ev1", 64'(log_ev[1]), 64'({1'b0, 6'd5}));
      end

      // Key 9 flips and reverts while key 1 occupies the slot.
      ready = 1'b0; log_ev.delete(); log_t.delete();
      phys = one36 << 1;
      wait_valid(5 * FRAME, "coalesce9 wait");
      chk("coalesce9 slot key", 64'(evt_if.event_key), 64'd1);
      phys = (one36 << 1) | (one36 << 9);
      frames(4);
      chk("coalesce9 pressed", 64'(key_state[9]), 64'd1);
      phys = one36 << 1;
      frames(4);
      chk("coalesce9 released", 64'(key_state[9]), 64'd0);
      ready = 1'b1;
      repeat (6) cyc();
      phys = '0;
      frames(4);
      chk("coalesce9 count", 64'(log_ev.size()), 64'd2);
      if (log_ev.size() >= 2) begin
         chk("coalesce9 ev0", 64'(log_ev[0]), 64'({1'b1, 6'd1}));
         chk("coalesce9 ev1", 64'(log_ev[1]), 64'({1'b0, 6'd1}));
      end

      // Reset while an event is presented.
      ready = 1'b0;
      phys = k14;
      wait_valid(5 * FRAME, "midreset wait");
      rst = 1'b0;
      cyc();
      chk("midreset valid", 64'(evt_if.event_valid), 64'd0);
      chk("midreset state", 64'(key_state), 64'd0);
      chk("midreset row", 64'(row_drive), 64'h3E);
      rst = 1'b1; ready = 1'b1; log_ev.delete(); log_t.delete();
      n = 0;
      while (log_ev.size() == 0 && n < 5 * FRAME) begin cyc(); n++; end
      chk("midreset re-report count", 64'(log_ev.size()), 64'd1);
      if (log_ev.size() >= 1) chk("midreset re-report ev", 64'(log_ev[0]), 64'({1'b1, 6'd14}));
      phys = '0;
      frames(4);

      // Randomized key activity, backpressure and occasional resets.
      for (int s = 0; s < 200; s++) begin
         int len;
         phys ^= one36 << $urandom_range(0, 35);
         if ($urandom_range(0, 3) == 0) phys ^= one36 << $urandom_range(0, 35);
         if ($countones(phys) > 6) phys = '0;
         len = $urandom_range(1, 150);
         if ($urandom_range(0, 2) == 0) len = len + 2 * FRAME;
         for (int i = 0; i < len; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 3999) != 0);
            cyc();
         end
      end
      rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
